// File: rtl/burst_write_master.sv
// rtl/burst_write_master.sv - Avalon-MM burst write master fed by a show-ahead FIFO
//
// Upstream logic pushes words into an internal FIFO; a ctrl_start pulse then
// issues exactly one write burst. The burst is launched only once every word
// of it is already buffered, so master_write never drops mid-burst.
//
// Ports:
//   clk                 system clock, rising edge
//   reset_n             asynchronous active-low reset
//   master_address      burst start byte address (held for the whole burst)
//   master_write        write request
//   master_writedata    FIFO head word (combinational, show-ahead)
//   master_burstcount   burst length in words (held for the whole burst)
//   master_byteenable   byte lane enables, constant all-ones
//   master_waitrequest  slave stall
//   ctrl_start          start request, sampled in IDLE only
//   ctrl_baseaddress    burst byte address
//   ctrl_burstcount     requested words, legal range 1..2^(BURST_WIDTH-1)
//   ctrl_busy           transfer in progress
//   ctrl_done           one-cycle pulse after the last beat
//   user_write          push user_writedata into the FIFO
//   user_writedata      data to buffer
//   user_full           FIFO full; pushes are dropped
//   user_used           words currently buffered
module burst_write_master #(
  parameter int ADDRESS_WIDTH     = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int BYTE_ENABLE_WIDTH = 4,
  parameter int BURST_WIDTH       = 4,
  parameter int FIFO_DEPTH        = 16,
  parameter int FIFO_DEPTH_LOG2   = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  output logic [ADDRESS_WIDTH-1:0]     master_address,
  output logic                         master_write,
  output logic [DATA_WIDTH-1:0]        master_writedata,
  output logic [BURST_WIDTH-1:0]       master_burstcount,
  output logic [BYTE_ENABLE_WIDTH-1:0] master_byteenable,
  input  logic                         master_waitrequest,
  input  logic                         ctrl_start,
  input  logic [ADDRESS_WIDTH-1:0]     ctrl_baseaddress,
  input  logic [BURST_WIDTH-1:0]       ctrl_burstcount,
  output logic                         ctrl_busy,
  output logic                         ctrl_done,
  input  logic                         user_write,
  input  logic [DATA_WIDTH-1:0]        user_writedata,
  output logic                         user_full,
  output logic [FIFO_DEPTH_LOG2:0]     user_used
);

  // Largest legal burst is 2^(BURST_WIDTH-1), i.e. only the MSB of burstcount set.
  localparam logic [BURST_WIDTH-1:0]   MAX_BURST   = {1'b1, {(BURST_WIDTH-1){1'b0}}};
  localparam logic [BURST_WIDTH-1:0]   ONE_BEAT    = {{(BURST_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_COUNT = FIFO_DEPTH[FIFO_DEPTH_LOG2:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_BURST,
    S_DONE
  } state_t;

  state_t state, state_nx;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]      mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   used;
  logic                       push;
  logic                       pop;

  assign push = user_write && (used != DEPTH_COUNT);
  // master_write is only raised once the whole burst is buffered, so a pop
  // can never hit an empty FIFO.
  assign pop  = master_write && !master_waitrequest;

  // Storage is not reset; emptiness is tracked solely by used.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= user_writedata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      // Pointers wrap naturally because FIFO_DEPTH is a power of two.
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   used <= used + 1'b1;
        2'b01:   used <= used - 1'b1;
        default: used <= used;
      endcase
    end
  end

  assign master_writedata  = mem[rd_ptr];
  assign master_byteenable = '1;
  assign user_full         = (used == DEPTH_COUNT);
  assign user_used         = used;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  logic [BURST_WIDTH-1:0]   remaining, remaining_nx;
  logic [ADDRESS_WIDTH-1:0] address_nx;
  logic [BURST_WIDTH-1:0]   burstcount_nx;
  logic                     write_nx;
  logic                     busy_nx;
  logic                     done_nx;
  logic                     start_legal;
  logic                     burst_buffered;

  assign start_legal    = (ctrl_burstcount != '0) && (ctrl_burstcount <= MAX_BURST);
  assign burst_buffered = (32'(used) >= 32'(master_burstcount));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      master_address    <= '0;
      master_burstcount <= '0;
      master_write      <= 1'b0;
      remaining         <= '0;
      ctrl_busy         <= 1'b0;
      ctrl_done         <= 1'b0;
    end else begin
      state             <= state_nx;
      master_address    <= address_nx;
      master_burstcount <= burstcount_nx;
      master_write      <= write_nx;
      remaining         <= remaining_nx;
      ctrl_busy         <= busy_nx;
      ctrl_done         <= done_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    address_nx    = master_address;
    burstcount_nx = master_burstcount;
    write_nx      = master_write;
    remaining_nx  = remaining;
    busy_nx       = ctrl_busy;
    done_nx       = ctrl_done;

    case (state)
      S_IDLE: begin
        // Starts with an out-of-range count are dropped without a trace.
        if (ctrl_start && start_legal) begin
          address_nx    = ctrl_baseaddress;
          burstcount_nx = ctrl_burstcount;
          remaining_nx  = ctrl_burstcount;
          busy_nx       = 1'b1;
          state_nx      = S_LOAD;
        end
      end

      S_LOAD: begin
        // Wait until every beat of the burst is already in the FIFO.
        if (burst_buffered) begin
          write_nx = 1'b1;
          state_nx = S_BURST;
        end
      end

      S_BURST: begin
        if (!master_waitrequest) begin
          remaining_nx = remaining - 1'b1;
          if (remaining == ONE_BEAT) begin
            write_nx = 1'b0;
            done_nx  = 1'b1;
            state_nx = S_DONE;
          end
        end
      end

      S_DONE: begin
        done_nx  = 1'b0;
        busy_nx  = 1'b0;
        state_nx = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_burst_write_master.sv
// tb/tb_burst_write_master.sv - self-checking bench for burst_write_master
module tb_burst_write_master;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BEW = 4;
  localparam int BW  = 4;
  localparam int FD  = 16;
  localparam int FDL = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [AW-1:0]  master_address;
  logic           master_write;
  logic [DW-1:0]  master_writedata;
  logic [BW-1:0]  master_burstcount;
  logic [BEW-1:0] master_byteenable;
  logic           master_waitrequest = 1'b0;
  logic           ctrl_start = 1'b0;
  logic [AW-1:0]  ctrl_baseaddress = '0;
  logic [BW-1:0]  ctrl_burstcount = '0;
  logic           ctrl_busy;
  logic           ctrl_done;
  logic           user_write = 1'b0;
  logic [DW-1:0]  user_writedata = '0;
  logic           user_full;
  logic [FDL:0]   user_used;

  burst_write_master #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_ENABLE_WIDTH(BEW),
    .BURST_WIDTH(BW), .FIFO_DEPTH(FD), .FIFO_DEPTH_LOG2(FDL)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .master_address(master_address), .master_write(master_write),
    .master_writedata(master_writedata), .master_burstcount(master_burstcount),
    .master_byteenable(master_byteenable), .master_waitrequest(master_waitrequest),
    .ctrl_start(ctrl_start), .ctrl_baseaddress(ctrl_baseaddress),
    .ctrl_burstcount(ctrl_burstcount), .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done),
    .user_write(user_write), .user_writedata(user_writedata),
    .user_full(user_full), .user_used(user_used)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: FIFO contents in push order plus the active transaction.
  logic [DW-1:0] model_q[$];
  logic [AW-1:0] exp_addr = '0;
  int  exp_cnt = 0;
  bit  txn_active = 0;
  bit  write_seen = 0;
  int  beats = 0;
  int  stalls = 0;
  int  cyc = 0;
  int  first_write_cyc = 0;
  int  last_span = 0;
  int  done_seen = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: inputs are already driven; check pre-edge bus state against the
  // model, advance the model by the edge, then check post-edge state.
  task automatic step();
    bit beat;
    bit do_push;
    beat    = master_write && !master_waitrequest;
    do_push = user_write && reset_n && (model_q.size() < FD);
    if (!txn_active) begin
      check_eq("write_outside_txn", master_write, 0);
    end else if (master_write) begin
      check_eq("address", master_address, exp_addr);
      check_eq("burstcount", master_burstcount, exp_cnt);
      if (!write_seen) begin
        write_seen = 1;
        first_write_cyc = cyc;
        check_eq("buffered_before_write", model_q.size() >= exp_cnt, 1);
      end
      if (master_waitrequest) stalls++;
    end
    if (beat) begin
      if (model_q.size() == 0) check_eq("pop_empty_fifo", master_write, 0);
      else check_eq("writedata", master_writedata, model_q[0]);
      beats++;
    end
    @(posedge clk);
    cyc++;
    if (beat && model_q.size() > 0) void'(model_q.pop_front());
    if (do_push) model_q.push_back(user_writedata);
    #1;
    check_eq("used", user_used, model_q.size());
    check_eq("full", user_full, model_q.size() == FD);
    if (ctrl_done) begin
      if (!txn_active) begin
        check_eq("spurious_done", ctrl_done, 0);
      end else begin
        done_seen++;
        last_span = cyc - first_write_cyc;
        check_eq("done_beats", beats, exp_cnt);
        check_eq("done_contiguous", last_span, beats + stalls);
        txn_active = 0;
      end
    end
  endtask

  task automatic push_word(input logic [DW-1:0] v);
    user_write = 1'b1;
    user_writedata = v;
    step();
    user_write = 1'b0;
  endtask

  task automatic fill(input int n);
    while (model_q.size() < n) push_word($urandom);
  endtask

  task automatic start_burst(input logic [AW-1:0] base, input int cnt);
    ctrl_start = 1'b1;
    ctrl_baseaddress = base;
    ctrl_burstcount = cnt[BW-1:0];
    if (cnt >= 1 && cnt <= 8) begin
      exp_addr = base; exp_cnt = cnt; beats = 0; stalls = 0;
      write_seen = 0; txn_active = 1;
    end
    step();
    ctrl_start = 1'b0;
    check_eq("busy_after_start", ctrl_busy, txn_active);
  endtask

  task automatic run_to_done(input int budget, input int wait_pct, input int push_pct,
                             input bit poke_start);
    bit poked = 0;
    for (int n = 0; n < budget && txn_active; n++) begin
      master_waitrequest = ($urandom_range(0, 99) < wait_pct);
      user_write = ($urandom_range(0, 99) < push_pct);
      user_writedata = $urandom;
      ctrl_start = 1'b0;
      if (poke_start && !poked && beats == 3) begin
        ctrl_start = 1'b1;
        ctrl_baseaddress = 32'h1234_5670;
        ctrl_burstcount = 4'd2;
        poked = 1;
      end
      step();
    end
    ctrl_start = 1'b0;
    user_write = 1'b0;
    master_waitrequest = 1'b0;
    check_eq("burst_completes", txn_active, 0);
    step();
    check_eq("busy_after_done", ctrl_busy, 0);
  endtask

  initial begin
    int done_before;
    int stall_left;
    int stall_beat;

    // Reset state
    step(); step();
    check_eq("rst_write", master_write, 0);
    check_eq("rst_busy", ctrl_busy, 0);
    check_eq("rst_done", ctrl_done, 0);
    check_eq("rst_address", master_address, 0);
    check_eq("rst_burstcount", master_burstcount, 0);
    check_eq("rst_byteenable", master_byteenable, 4'hF);
    reset_n = 1'b1;
    step();

    // 1. Basic burst with exact latency
    for (int i = 1; i <= 8; i++) push_word(DW'(i));
    start_burst(32'h3900_0000, 8);
    check_eq("t1_write_at_n", master_write, 0);
    step();
    check_eq("t1_write_at_n1", master_write, 1);
    for (int i = 0; i < 8; i++) begin
      check_eq("t1_write_hi", master_write, 1);
      check_eq("t1_done_lo", ctrl_done, 0);
      step();
    end
    check_eq("t1_done_pulse", ctrl_done, 1);
    check_eq("t1_write_lo", master_write, 0);
    check_eq("t1_busy_with_done", ctrl_busy, 1);
    step();
    check_eq("t1_busy_fall", ctrl_busy, 0);
    check_eq("t1_done_fall", ctrl_done, 0);
    check_eq("t1_used_end", user_used, 0);

    // 2. Start before data, one push every 3 cycles
    start_burst(32'h0000_1000, 4);
    for (int n = 0; n < 100 && txn_active; n++) begin
      user_write = (n % 3 == 0);
      user_writedata = 32'h200 + DW'(n);
      step();
    end
    user_write = 1'b0;
    check_eq("t2_completes", txn_active, 0);
    check_eq("t2_span", last_span, 4);
    step();

    // 3. Waitrequest on beats 1, 4 and 8 for two cycles each
    fill(8);
    start_burst(32'h0000_2000, 8);
    stall_left = 0;
    stall_beat = -1;
    for (int n = 0; n < 60 && txn_active; n++) begin
      if (master_write && (beats == 0 || beats == 3 || beats == 7) && stall_beat != beats) begin
        stall_beat = beats;
        stall_left = 2;
      end
      master_waitrequest = (stall_left > 0);
      if (stall_left > 0) stall_left--;
      step();
    end
    master_waitrequest = 1'b0;
    check_eq("t3_completes", txn_active, 0);
    check_eq("t3_span", last_span, 14);
    step();

    // 4. FIFO boundaries: 17 pushes, then two bursts with concurrent pushes
    for (int i = 0; i < 17; i++) begin
      push_word(32'h400 + DW'(i));
      if (i == 15) check_eq("t4_full_at_16", user_full, 1);
    end
    check_eq("t4_used_after_17", user_used, 16);
    start_burst(32'h0000_3000, 8);
    run_to_done(100, 20, 50, 0);
    start_burst(32'h0000_3020, 8);
    run_to_done(100, 20, 50, 0);

    // 5. Illegal counts and start while busy
    fill(9);
    start_burst(32'h0000_4000, 0);
    for (int i = 0; i < 3; i++) step();
    check_eq("t5_busy_cnt0", ctrl_busy, 0);
    start_burst(32'h0000_4000, 9);
    for (int i = 0; i < 3; i++) step();
    check_eq("t5_busy_cnt9", ctrl_busy, 0);
    done_before = done_seen;
    start_burst(32'h0000_5000, 8);
    run_to_done(100, 20, 0, 1);
    for (int i = 0; i < 5; i++) step();
    check_eq("t5_single_done", done_seen - done_before, 1);
    check_eq("t5_idle_busy", ctrl_busy, 0);

    // Randomized bursts
    for (int k = 0; k < 8; k++) begin
      int cnt;
      cnt = $urandom_range(1, 8);
      fill(cnt);
      start_burst($urandom & 32'hFFFF_FFFC, cnt);
      run_to_done(200, 30, 30, 0);
    end

    // 6. Asynchronous reset after beat 3 of 8
    fill(8);
    start_burst(32'h0000_6000, 8);
    for (int n = 0; n < 40 && beats < 3; n++) step();
    check_eq("t6_three_beats", beats, 3);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t6_rst_write", master_write, 0);
    check_eq("t6_rst_busy", ctrl_busy, 0);
    check_eq("t6_rst_used", user_used, 0);
    model_q.delete();
    txn_active = 0;
    step(); step();
    reset_n = 1'b1;
    step();
    push_word(32'hA5A5_0001);
    push_word(32'hA5A5_0002);
    start_burst(32'h0000_7000, 2);
    run_to_done(50, 0, 0, 0);
    check_eq("t6_clean_beats", beats, 2);
    check_eq("t6_used_end", user_used, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/burst_write_master.md
Name: burst_write_master

Overview:
- Avalon-MM burst write master. It is the write-direction counterpart of the team's burst read master.
- Upstream logic pushes words into an internal show-ahead FIFO.
- A control pulse then issues exactly one write burst of the requested length to SDRAM/HPS memory at a given byte address.
- The burst is launched only after the whole burst is buffered, so master_write never drops mid-burst.

Parameters:
ADDRESS_WIDTH, 32, byte address width
DATA_WIDTH, 32, data word width
BYTE_ENABLE_WIDTH, 4, DATA_WIDTH/8
BURST_WIDTH, 4, burstcount width; max legal burst = 2^(BURST_WIDTH-1) = 8
FIFO_DEPTH, 16, buffer words; must be >= max burst
FIFO_DEPTH_LOG2, 4, log2(FIFO_DEPTH)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
master_address  out  ADDRESS_WIDTH  burst start byte address
master_write  out  1  write request
master_writedata  out  DATA_WIDTH  FIFO head word
master_burstcount  out  BURST_WIDTH  burst length in words
master_byteenable  out  BYTE_ENABLE_WIDTH  byte lane enables
master_waitrequest  in  1  slave stall
ctrl_start  in  1  start request, sampled in IDLE only
ctrl_baseaddress  in  ADDRESS_WIDTH  burst byte address
ctrl_burstcount  in  BURST_WIDTH  requested words
ctrl_busy  out  1  transfer in progress
ctrl_done  out  1  one-cycle pulse, burst complete
user_write  in  1  push user_writedata into FIFO
user_writedata  in  DATA_WIDTH  data to buffer
user_full  out  1  FIFO full; pushes ignored
user_used  out  FIFO_DEPTH_LOG2+1  words currently buffered

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
  - While reset_n=0: all registered outputs are 0, the state is IDLE and the FIFO is emptied (used=0).
  - master_byteenable is constant all-ones, including during reset.
- Registered outputs: all control outputs are registered. master_writedata is driven combinationally from the FIFO head (show-ahead).
- FIFO push and pop:
  - Push happens when user_write=1 and used<FIFO_DEPTH.
  - Pop happens when master_write=1 and master_waitrequest=0.
  - A simultaneous push and pop leaves used unchanged. Pointers wrap modulo FIFO_DEPTH.
  - A push while full is dropped silently; used and the stored data are unchanged.
  - user_full = (used==FIFO_DEPTH). user_used = used.
- IDLE:
  - Enter LOAD when ctrl_start=1 and 1 <= ctrl_burstcount <= 2^(BURST_WIDTH-1).
  - On entry, latch master_address<=ctrl_baseaddress, master_burstcount<=ctrl_burstcount and remaining<=ctrl_burstcount, and set ctrl_busy<=1.
  - ctrl_start with an illegal count (0 or >8) is ignored; the block stays in IDLE and ctrl_busy stays 0.
- LOAD:
  - When used >= master_burstcount, set master_write<=1 and go to BURST.
  - Otherwise wait indefinitely, with master_write=0.
- BURST:
  - master_address and master_burstcount are held constant for the whole burst.
  - Each cycle with master_waitrequest=0 pops one word and decrements remaining.
  - When the beat accepted has remaining==1: master_write<=0, ctrl_done<=1, go to DONE.
  - While master_waitrequest=1: all master outputs are held and nothing pops.
  - Pushes during BURST are allowed. Words beyond the burst stay buffered for the next start.
- DONE (one cycle): ctrl_done<=0, ctrl_busy<=0, return to IDLE. A new start is accepted from the following cycle.
- Start while busy: ctrl_start outside IDLE is ignored; it is not queued.
- Latency: with data already buffered, a ctrl_start sampled at edge N gives ctrl_busy=1 after N, master_write=1 after N+1.
  - With no waitrequest, a burst of B words takes beats on edges N+2..N+B+1.
  - ctrl_done is high for the cycle after the last beat.
  - ctrl_busy falls one edge after ctrl_done rises.
- Reset mid-burst: the burst is abandoned immediately, the FIFO contents are lost, and the block restarts in IDLE.
- Internal counter widths: remaining is BURST_WIDTH bits. used is FIFO_DEPTH_LOG2+1 bits and saturates in neither direction; the logic never pushes when full or pops when empty.

Test Plan:
1. Basic burst:
   - Stimulus: reset; push 8 words 0x00000001..0x00000008; ctrl_start with base=0x39000000, count=8; waitrequest=0.
   - Required: master_write high for 8 consecutive cycles; address=0x39000000 and burstcount=8 stable throughout; writedata sequence 1..8; one ctrl_done pulse; used=0 at end.
2. Start before data:
   - Stimulus: ctrl_start with count=4 and FIFO empty; push one word every 3 cycles.
   - Required: master_write stays 0 until used reaches 4, then 4 contiguous beats with no gaps.
3. Waitrequest stalls:
   - Stimulus: count=8; waitrequest high on beats 1, 4 and 8 for 2 cycles each.
   - Required: writedata and address held during each stall; exactly 8 pops; burst completes after 14 active cycles.
4. FIFO boundaries:
   - Stimulus: push 17 words with FIFO_DEPTH=16.
   - Required: user_full=1 after the 16th; 17th word dropped.
   - Stimulus: then run two bursts of 8 while pushing simultaneously.
   - Required: pointers wrap; the data order matches the push order; the dropped word never appears.
5. Illegal and ignored starts:
   - Stimulus: ctrl_start with count=0, then count=9.
   - Required: ctrl_busy stays 0 and no write occurs.
   - Stimulus: ctrl_start pulsed mid-burst.
   - Required: ignored; exactly one ctrl_done.
6. Reset mid-burst:
   - Stimulus: reset_n=0 asynchronously after beat 3 of 8.
   - Required: master_write, ctrl_busy and user_used drop to 0 immediately.
   - Stimulus: after release, push 2 words and start with count=2.
   - Required: 2 clean beats.
